// File: rtl/pq_cmd_sequencer.sv
// Command front-end for the systolic min priority queue: buffers ENQ/DEQ/REPLACE
// commands, issues one strobe per legal command, enforces the settle gap, returns responses.
module pq_cmd_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int CMD_DEPTH  = 4,
  parameter int ENQ_GAP    = 2,
  parameter int DEQ_GAP    = 3
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [1:0]            i_cmd_op,
  input  logic [DATA_WIDTH-1:0] i_cmd_data,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic                  o_rsp_err,
  output logic                  o_pq_wrt,
  output logic                  o_pq_read,
  output logic [DATA_WIDTH-1:0] o_pq_data,
  input  logic                  i_pq_full,
  input  logic                  i_pq_empty,
  input  logic [DATA_WIDTH-1:0] i_pq_data
);

  localparam int PW = $clog2(CMD_DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;
  localparam logic [7:0]  CNT_ONE = 8'd1;
  localparam logic [7:0]  ENQ_G   = 8'(ENQ_GAP);
  localparam logic [7:0]  DEQ_G   = 8'(DEQ_GAP);

  typedef enum logic [1:0] {OP_ENQ = 2'b00, OP_DEQ = 2'b01, OP_REP = 2'b10, OP_ILL = 2'b11} op_e;
  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, RESP} state_e;

  state_e                  state;
  op_e                     op_q;
  logic [7:0]              cnt;
  logic [DATA_WIDTH+1:0]   fifo_mem [CMD_DEPTH];
  logic [PW:0]             wr_ptr;
  logic [PW:0]             rd_ptr;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    push;
  logic                    pop;
  op_e                     head_op;
  logic [DATA_WIDTH-1:0]   head_data;
  logic                    head_illegal;
  logic [7:0]              issue_gap;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign o_cmd_ready = !fifo_full;
  assign push        = i_cmd_valid && o_cmd_ready;
  assign pop         = (state == IDLE) && !fifo_empty;
  assign head_op     = op_e'(fifo_mem[rd_ptr[PW-1:0]][DATA_WIDTH+1:DATA_WIDTH]);
  assign head_data   = fifo_mem[rd_ptr[PW-1:0]][DATA_WIDTH-1:0];
  assign issue_gap   = (op_q == OP_ENQ) ? ENQ_G : DEQ_G;

  always_comb begin
    head_illegal = 1'b0;
    case (head_op)
      OP_ENQ:  head_illegal = i_pq_full;
      OP_DEQ:  head_illegal = i_pq_empty;
      OP_REP:  head_illegal = i_pq_empty;
      default: head_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr[PW-1:0]] <= {i_cmd_op, i_cmd_data};
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state       <= IDLE;
      op_q        <= OP_ENQ;
      cnt         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_rsp_err   <= 1'b0;
      o_pq_wrt    <= 1'b0;
      o_pq_read   <= 1'b0;
      o_pq_data   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            op_q <= head_op;
            if (head_illegal) begin
              state       <= RESP;
              o_rsp_valid <= 1'b1;
              o_rsp_err   <= 1'b1;
              o_rsp_data  <= (head_op == OP_DEQ) ? '1 : '0;
            end else begin
              state     <= ISSUE;
              o_pq_wrt  <= (head_op != OP_DEQ);
              o_pq_read <= (head_op != OP_ENQ);
              o_pq_data <= head_data;
            end
          end
        end
        ISSUE: begin
          o_pq_wrt   <= 1'b0;
          o_pq_read  <= 1'b0;
          o_rsp_err  <= 1'b0;
          o_rsp_data <= (op_q == OP_ENQ) ? '0 : i_pq_data;
          if (issue_gap == '0) begin
            state       <= RESP;
            o_rsp_valid <= 1'b1;
          end else begin
            cnt   <= issue_gap;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt <= CNT_ONE) begin
            cnt         <= '0;
            state       <= RESP;
            o_rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pq_cmd_sequencer.sv
// Bench for pq_cmd_sequencer: a sorted-queue model of the priority queue plus a
// command-order reference model; directed scenarios followed by randomized traffic.
module tb_pq_cmd_sequencer;

  localparam int DW = 16;
  localparam int DEPTH = 4;
  localparam int EG = 2;
  localparam int DG = 3;
  localparam int QS = 8;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          i_cmd_valid = 1'b0;
  logic          o_cmd_ready;
  logic [1:0]    i_cmd_op = '0;
  logic [DW-1:0] i_cmd_data = '0;
  logic          o_rsp_valid;
  logic          i_rsp_ready = 1'b0;
  logic [DW-1:0] o_rsp_data;
  logic          o_rsp_err;
  logic          o_pq_wrt;
  logic          o_pq_read;
  logic [DW-1:0] o_pq_data;
  logic          i_pq_full = 1'b0;
  logic          i_pq_empty = 1'b1;
  logic [DW-1:0] i_pq_data = '1;

  always #5 CLK = ~CLK;

  pq_cmd_sequencer #(.DATA_WIDTH(DW), .CMD_DEPTH(DEPTH), .ENQ_GAP(EG), .DEQ_GAP(DG)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_op(i_cmd_op), .i_cmd_data(i_cmd_data),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
    .o_pq_wrt(o_pq_wrt), .o_pq_read(o_pq_read), .o_pq_data(o_pq_data),
    .i_pq_full(i_pq_full), .i_pq_empty(i_pq_empty), .i_pq_data(i_pq_data)
  );

  typedef struct { logic [DW-1:0] data; logic err; int gap; } rsp_t;
  typedef struct { logic wrt; logic rd; logic [DW-1:0] d; int gap; } iss_t;

  int n_cmp = 0;
  int n_mis = 0;
  logic [DW-1:0] env_q[$];
  logic [DW-1:0] ref_q[$];
  rsp_t exp_rsp[$];
  iss_t exp_iss[$];
  int cyc = 0, last_pulse = 0, last_gap = 0, n_pulses = 0, n_rsp_rise = 0;
  logic have_pulse = 1'b0, prev_rv = 1'b0;
  int rsp_mode = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int find_pos(input logic [DW-1:0] qq[$], input logic [DW-1:0] v);
    int p = 0;
    while (p < qq.size() && qq[p] <= v) p++;
    return p;
  endfunction

  // Priority queue environment: reacts to strobes at the clock edge, min at the front.
  always @(posedge CLK) begin
    if (o_pq_read && env_q.size() > 0) void'(env_q.pop_front());
    if (o_pq_wrt && env_q.size() < QS) env_q.insert(find_pos(env_q, o_pq_data), o_pq_data);
    i_pq_empty <= (env_q.size() == 0);
    i_pq_full  <= (env_q.size() == QS);
    i_pq_data  <= (env_q.size() == 0) ? '1 : env_q[0];
  end

  task automatic model_accept(input logic [1:0] op, input logic [DW-1:0] d);
    rsp_t r;
    iss_t s;
    r.err = 1'b0; r.data = '0; r.gap = 0;
    s.wrt = 1'b0; s.rd = 1'b0; s.d = d; s.gap = 0;
    case (op)
      2'd0: if (ref_q.size() == QS) r.err = 1'b1;
            else begin ref_q.insert(find_pos(ref_q, d), d); s.wrt = 1'b1; r.gap = EG; end
      2'd1: if (ref_q.size() == 0) begin r.err = 1'b1; r.data = '1; end
            else begin r.data = ref_q.pop_front(); s.rd = 1'b1; r.gap = DG; end
      2'd2: if (ref_q.size() == 0) r.err = 1'b1;
            else begin
              r.data = ref_q.pop_front();
              ref_q.insert(find_pos(ref_q, d), d);
              s.wrt = 1'b1; s.rd = 1'b1; r.gap = DG;
            end
      default: r.err = 1'b1;
    endcase
    if (!r.err) begin s.gap = r.gap; exp_iss.push_back(s); end
    exp_rsp.push_back(r);
  endtask

  // Monitor: samples on the falling edge, mid-cycle.
  always @(negedge CLK) begin
    if (!RSTn) begin
      exp_rsp.delete();
      exp_iss.delete();
      have_pulse = 1'b0;
      prev_rv = 1'b0;
    end else begin
      cyc++;
      if (o_pq_wrt || o_pq_read) begin
        n_pulses++;
        if (exp_iss.size() == 0) check_eq("unexpected_pulse", 32'd1, 32'd0);
        else begin
          iss_t it;
          it = exp_iss.pop_front();
          check_eq("pq_wrt", 32'(o_pq_wrt), 32'(it.wrt));
          check_eq("pq_read", 32'(o_pq_read), 32'(it.rd));
          if (it.wrt) check_eq("pq_data", 32'(o_pq_data), 32'(it.d));
          if (have_pulse) check_eq("pulse_spacing", 32'(cyc - last_pulse >= last_gap + 3), 32'd1);
          last_pulse = cyc;
          last_gap = it.gap;
          have_pulse = 1'b1;
        end
      end
      if (o_rsp_valid && !prev_rv) begin
        n_rsp_rise++;
        if (exp_rsp.size() == 0) check_eq("spurious_rsp", 32'd1, 32'd0);
        else if (!exp_rsp[0].err) check_eq("rsp_latency", 32'(cyc - last_pulse), 32'(exp_rsp[0].gap + 1));
      end
      if (o_rsp_valid && i_rsp_ready && exp_rsp.size() > 0) begin
        rsp_t r;
        r = exp_rsp.pop_front();
        check_eq("rsp_data", 32'(o_rsp_data), 32'(r.data));
        check_eq("rsp_err", 32'(o_rsp_err), 32'(r.err));
      end
      if (i_cmd_valid && o_cmd_ready) model_accept(i_cmd_op, i_cmd_data);
      prev_rv = o_rsp_valid;
    end
  end

  always begin
    @(posedge CLK); #1;
    case (rsp_mode)
      0: i_rsp_ready = 1'b1;
      1: i_rsp_ready = 1'b0;
      default: i_rsp_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic send_cmd(input logic [1:0] op, input logic [DW-1:0] d);
    int k;
    i_cmd_valid = 1'b1; i_cmd_op = op; i_cmd_data = d;
    for (k = 0; k < 500; k++) begin
      @(negedge CLK);
      if (o_cmd_ready) break;
    end
    if (k == 500) check_eq("cmd_accept_timeout", 32'd0, 32'd1);
    @(posedge CLK); #1;
    i_cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge CLK);
      if (exp_rsp.size() == 0 && !o_rsp_valid) break;
    end
    if (k == 3000) check_eq("drain_timeout", 32'd0, 32'd1);
    check_eq("rsp_outstanding", 32'(exp_rsp.size()), 32'd0);
    @(posedge CLK); #1;
  endtask

  initial begin
    int acc, p0, r0, k;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check_eq("rst_strobes", 32'({o_pq_wrt, o_pq_read}), 32'd0);
    check_eq("rst_rsp_data", 32'({o_rsp_err, o_rsp_data}), 32'd0);
    check_eq("rst_pq_data", 32'(o_pq_data), 32'd0);
    RSTn = 1'b1;
    @(posedge CLK); #1;

    // Three enqueues into an empty queue.
    send_cmd(2'd0, 16'd300); send_cmd(2'd0, 16'd20); send_cmd(2'd0, 16'd700);
    drain();
    check_eq("t1_head", 32'(i_pq_data), 32'd20);

    // Four dequeues; the last one finds the queue empty.
    repeat (4) send_cmd(2'd1, 16'd0);
    drain();

    // Fill, overflow enqueue, then replace the head.
    for (int i = 0; i < QS; i++) send_cmd(2'd0, 16'($urandom_range(100, 60000)));
    send_cmd(2'd0, 16'd5);
    send_cmd(2'd2, 16'd1);
    drain();
    check_eq("t3_head", 32'(i_pq_data), 32'd1);

    // Response backpressure: one command in flight plus a full FIFO.
    rsp_mode = 1;
    @(posedge CLK); #1;
    p0 = n_pulses;
    acc = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      i_cmd_valid = 1'b1; i_cmd_op = 2'd1; i_cmd_data = '0;
      @(negedge CLK);
      if (!o_cmd_ready) break;
      acc++;
      @(posedge CLK); #1;
    end
    @(posedge CLK); #1;
    i_cmd_valid = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
    check_eq("t4_accepts", 32'(acc), 32'(DEPTH + 1));
    check_eq("t4_ready_low", 32'(o_cmd_ready), 32'd0);
    check_eq("t4_single_pulse", 32'(n_pulses - p0), 32'd1);
    rsp_mode = 0;
    drain();

    // Illegal opcode followed by a normal enqueue.
    send_cmd(2'd3, 16'h1234);
    send_cmd(2'd0, 16'd42);
    drain();

    // Randomized traffic with random response backpressure.
    rsp_mode = 2;
    for (int i = 0; i < 300; i++) begin
      int r;
      logic [1:0] op;
      r = $urandom_range(0, 99);
      op = (r < 40) ? 2'd0 : (r < 75) ? 2'd1 : (r < 95) ? 2'd2 : 2'd3;
      send_cmd(op, 16'($urandom_range(0, 65534)));
      repeat ($urandom_range(0, 2)) @(posedge CLK);
      #1;
    end
    rsp_mode = 0;
    drain();

    // Reset while a dequeue is settling.
    send_cmd(2'd0, 16'd77);
    drain();
    send_cmd(2'd1, 16'd0);
    for (k = 0; k < 50; k++) begin
      @(negedge CLK);
      if (o_pq_read) break;
    end
    check_eq("t6_pulse_seen", 32'(k < 50), 32'd1);
    @(posedge CLK); #1;
    RSTn = 1'b0;
    #1;
    check_eq("t6_strobes", 32'({o_pq_wrt, o_pq_read}), 32'd0);
    check_eq("t6_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check_eq("t6_cmd_ready", 32'(o_cmd_ready), 32'd1);
    repeat (2) @(posedge CLK);
    #1;
    RSTn = 1'b1;
    r0 = n_rsp_rise;
    repeat (15) @(posedge CLK);
    #1;
    check_eq("t6_no_stale_rsp", 32'(n_rsp_rise - r0), 32'd0);
    send_cmd(2'd0, 16'd9);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
